// File: rtl/lsu_bus_pkg.sv
// lsu_bus_pkg: size encodings, FSM states and the alignment/legality check for the LSU bus interface
package lsu_bus_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  typedef enum logic [1:0] {IDLE, BUS, RESP} lsu_state_e;
  function automatic logic lsu_bad(input logic [1:0] size, input logic [2:0] a, input int dw);
    return (size == SZ_D && dw == 32) || (size == SZ_H && a[0]) ||
           (size == SZ_W && a[1:0] != 2'b00) || (size == SZ_D && a != 3'b000);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: places store data on byte lanes and extracts/extends load data from byte lanes
// Ports: i_st_off/i_st_size/i_wdata -> o_wdata (store lane placement);
//        i_ld_off/i_ld_size/i_unsigned/i_rdata -> o_rdata (load extraction + sign/zero extension)
module lsu_lane_align
  import lsu_bus_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]  i_st_off,
  input  logic [1:0]        i_st_size,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [OFF_W-1:0]  i_ld_off,
  input  logic [1:0]        i_ld_size,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] w_st_mask, w_ld_mask, w_ld_sh;
  logic              w_sign;
  // shifting all-ones by >= DATA_W yields zero, so full-width sizes get an all-ones mask
  assign w_st_mask = ~({DATA_W{1'b1}} << (8 << i_st_size));
  assign w_ld_mask = ~({DATA_W{1'b1}} << (8 << i_ld_size));
  assign o_wdata   = (i_wdata & w_st_mask) << {i_st_off, 3'b000};
  assign w_ld_sh   = i_rdata >> {i_ld_off, 3'b000};
  assign w_sign    = i_ld_size == SZ_B ? w_ld_sh[7] :
                     i_ld_size == SZ_H ? w_ld_sh[15] :
                     i_ld_size == SZ_W ? w_ld_sh[31] : w_ld_sh[DATA_W-1];
  assign o_rdata   = (w_ld_sh & w_ld_mask) | ((w_sign && !i_unsigned) ? ~w_ld_mask : '0);
endmodule

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: core valid/ready load/store requests to a DAD/DDT/MREQ/ACKD_n memory bus with wait states
// Ports: core request (req_*), core response (resp_*), bus outputs DAD/MREQ/WRITE/SIZE/ddt_out/ddt_oe,
//        bus inputs ddt_in/ACKD_n; clk, async active-low rst_n.
// Optional LSU_TIMEOUT_EN: abort a bus access with resp_err after TIMEOUT_CYC cycles without acknowledge.
module lsu_bus_if
  import lsu_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] DAD,
  output logic              MREQ,
  output logic              WRITE,
  output logic [1:0]        SIZE,
  output logic [DATA_W-1:0] ddt_out,
  output logic              ddt_oe,
  input  logic [DATA_W-1:0] ddt_in,
  input  logic              ACKD_n
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  lsu_state_e        r_state;
  logic              r_mreq, r_write, r_ddt_oe, r_unsigned, r_resp_valid, r_resp_err;
  logic [ADDR_W-1:0] r_dad;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_ddt_out, r_resp_rdata, w_wdata_lane, w_rdata_ext;
`ifdef LSU_TIMEOUT_EN
  localparam int WT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WT_W-1:0]   r_wait;
`else
  logic              w_unused_cfg;
  assign w_unused_cfg = TIMEOUT_CYC != 0;
`endif
  assign req_ready  = r_state == IDLE;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign DAD        = r_dad;
  assign MREQ       = r_mreq;
  assign WRITE      = r_write;
  assign SIZE       = r_size;
  assign ddt_out    = r_ddt_out;
  assign ddt_oe     = r_ddt_oe;
  // store placement uses the incoming request; load extraction uses the held bus access
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_st_off  (req_addr[OFF_W-1:0]),
    .i_st_size (req_size),
    .i_wdata   (req_wdata),
    .o_wdata   (w_wdata_lane),
    .i_ld_off  (r_dad[OFF_W-1:0]),
    .i_ld_size (r_size),
    .i_unsigned(r_unsigned),
    .i_rdata   (ddt_in),
    .o_rdata   (w_rdata_ext)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mreq       <= 1'b0;
      r_write      <= 1'b0;
      r_ddt_oe     <= 1'b0;
      r_unsigned   <= 1'b0;
      r_dad        <= '0;
      r_size       <= SZ_B;
      r_ddt_out    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
`ifdef LSU_TIMEOUT_EN
      r_wait       <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: if (req_valid) begin
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          if (lsu_bad(req_size, req_addr[2:0], DATA_W)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else begin
            r_state    <= BUS;
            r_mreq     <= 1'b1;
            r_write    <= req_write;
            r_ddt_oe   <= req_write;
            r_dad      <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_ddt_out  <= req_write ? w_wdata_lane : '0;
`ifdef LSU_TIMEOUT_EN
            r_wait     <= '0;
`endif
          end
        end
        BUS: if (!ACKD_n) begin
          r_state      <= RESP;
          r_mreq       <= 1'b0;
          r_write      <= 1'b0;
          r_ddt_oe     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_write ? '0 : w_rdata_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (r_wait == WT_W'(TIMEOUT_CYC - 1)) begin
          r_state      <= RESP;
          r_mreq       <= 1'b0;
          r_write      <= 1'b0;
          r_ddt_oe     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
        end else r_wait <= r_wait + 1'b1;
`endif
        RESP: if (resp_ready) begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
